// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: parallel-loads two operands on start, then
// compares one bit pair per clock (LSB- or MSB-first, unsigned or signed).
module serial_magnitude_comparator #(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             signed_mode,
   input  logic             msb_first,
   output logic             busy,
   output logic             done,
   output logic             L,
   output logic             E,
   output logic             G
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {R_EQ, R_LT, R_GT} res_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_signed;
   logic             r_msb;
   logic [CW-1:0]    r_cnt;
   res_t             r_res;
   res_t             w_res;
   res_t             w_bit_res;
   logic             r_l;
   logic             r_e;
   logic             r_g;
   logic             w_a_bit;
   logic             w_b_bit;
   logic             w_sign_bit;
   logic             w_diff;
   logic             w_last;

   assign w_a_bit    = r_msb ? r_a[WIDTH-1] : r_a[0];
   assign w_b_bit    = r_msb ? r_b[WIDTH-1] : r_b[0];
   // Sign bit is consumed first when MSB-first, last when LSB-first.
   assign w_sign_bit = r_msb ? (r_cnt == '0) : (r_cnt == LAST);
   assign w_diff     = w_a_bit ^ w_b_bit;
   assign w_bit_res  = (w_a_bit ^ (r_signed & w_sign_bit)) ? R_GT : R_LT;
   assign w_last     = (r_cnt == LAST) || (EARLY_EXIT && r_msb && w_diff);

   always_comb begin
      w_res = r_res;
      if (w_diff && (!r_msb || r_res == R_EQ))
         w_res = w_bit_res;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_msb    <= 1'b0;
         r_cnt    <= '0;
         r_res    <= R_EQ;
         r_l      <= 1'b0;
         r_e      <= 1'b0;
         r_g      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= a_in;
                  r_b      <= b_in;
                  r_signed <= signed_mode;
                  r_msb    <= msb_first;
                  r_cnt    <= '0;
                  r_res    <= R_EQ;
                  r_l      <= 1'b0;
                  r_e      <= 1'b0;
                  r_g      <= 1'b0;
               end
            end
            S_RUN: begin
               if (r_msb) begin
                  r_a <= {r_a[WIDTH-2:0], 1'b0};
                  r_b <= {r_b[WIDTH-2:0], 1'b0};
               end else begin
                  r_a <= {1'b0, r_a[WIDTH-1:1]};
                  r_b <= {1'b0, r_b[WIDTH-1:1]};
               end
               r_res <= w_res;
               if (w_last) begin
                  r_l <= (w_res == R_LT);
                  r_e <= (w_res == R_EQ);
                  r_g <= (w_res == R_GT);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign L = r_l;
   assign E = r_e;
   assign G = r_g;

endmodule
